// File: rtl/board_gpio.sv
// Board switch/LED front end: synchronises, debounces and edge-detects switch pins,
// drives polarity-corrected LED pins and exposes everything through a small register bus.
module board_gpio #(
    parameter int N_SW            = 6,
    parameter int N_LED           = 6,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int SW_ACTIVE_LOW   = 1,
    parameter int LED_ACTIVE_LOW  = 1,
    parameter logic [N_LED-1:0] LED_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SW-1:0]   switch_n,
    output logic [N_LED-1:0]  led_n,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [2:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ack,
    output logic              irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_SW-1:0]  SW_INACTIVE = (SW_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [N_LED-1:0] LED_MASK    = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    localparam logic [2:0] REG_SW_STATE = 3'd0;
    localparam logic [2:0] REG_SW_EDGE  = 3'd1;
    localparam logic [2:0] REG_LED_OUT  = 3'd2;
    localparam logic [2:0] REG_LED_SET  = 3'd3;
    localparam logic [2:0] REG_LED_CLR  = 3'd4;
    localparam logic [2:0] REG_IRQ_EN   = 3'd5;

    logic [N_SW-1:0]  sync_a;
    logic [N_SW-1:0]  sync_b;
    logic [N_SW-1:0]  logical;
    logic [N_SW-1:0]  stable;
    logic [N_SW-1:0]  stable_d;
    logic [N_SW-1:0]  rise;
    logic [N_SW-1:0]  edge_bits;
    logic [N_SW-1:0]  clr_mask;
    logic [N_SW-1:0]  irq_en;
    logic [N_SW-1:0]  irq_en_next;
    logic [N_SW-1:0]  wdata_sw;
    logic [N_LED-1:0] led_reg;
    logic [N_LED-1:0] led_next;
    logic [N_LED-1:0] wdata_led;
    logic [31:0]      read_value;
    logic             access;
    logic             wdata_unused;

    // Sync flops reset to the idle pin level so no phantom press appears at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= SW_INACTIVE;
            sync_b <= SW_INACTIVE;
        end else begin
            sync_a <= switch_n;
            sync_b <= sync_a;
        end
    end

    assign logical = sync_b ^ SW_INACTIVE;

    for (genvar i = 0; i < N_SW; i++) begin : g_debounce
        logic [CW-1:0] count;
        logic          stable_bit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count      <= '0;
                stable_bit <= 1'b0;
            end else if (logical[i] == stable_bit) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                count      <= '0;
                stable_bit <= logical[i];
            end else begin
                count <= count + CW'(1);
            end
        end

        assign stable[i] = stable_bit;
    end

    assign access       = bus_req & ~bus_ack;
    assign wdata_sw     = bus_wdata[N_SW-1:0];
    assign wdata_led    = bus_wdata[N_LED-1:0];
    assign wdata_unused = ^bus_wdata;
    assign rise         = stable & ~stable_d;
    assign clr_mask     = (access && bus_we && bus_addr == REG_SW_EDGE) ? wdata_sw : '0;

    always_comb begin
        read_value = '0;
        case (bus_addr)
            REG_SW_STATE: read_value[N_SW-1:0]  = stable;
            REG_SW_EDGE:  read_value[N_SW-1:0]  = edge_bits;
            REG_LED_OUT:  read_value[N_LED-1:0] = led_reg;
            REG_IRQ_EN:   read_value[N_SW-1:0]  = irq_en;
            default:      read_value = '0;
        endcase
    end

    always_comb begin
        led_next    = led_reg;
        irq_en_next = irq_en;
        if (access && bus_we) begin
            case (bus_addr)
                REG_LED_OUT: led_next    = wdata_led;
                REG_LED_SET: led_next    = led_reg | wdata_led;
                REG_LED_CLR: led_next    = led_reg & ~wdata_led;
                REG_IRQ_EN:  irq_en_next = wdata_sw;
                default:     led_next    = led_reg;
            endcase
        end
    end

    // A rising edge arriving together with a W1C clear wins, so no press is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d  <= '0;
            edge_bits <= '0;
            irq_en    <= '0;
            irq       <= 1'b0;
        end else begin
            stable_d  <= stable;
            edge_bits <= (edge_bits & ~clr_mask) | rise;
            irq_en    <= irq_en_next;
            irq       <= |(edge_bits & irq_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg <= LED_RESET;
            led_n   <= LED_RESET ^ LED_MASK;
        end else begin
            led_reg <= led_next;
            led_n   <= led_reg ^ LED_MASK;
        end
    end

    // The ack cycle itself never starts an access, so a held request alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= access;
            bus_rdata <= (access && !bus_we) ? read_value : '0;
        end
    end

endmodule
